// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined opcode decoder carrying control through EX, MEM and WB
module ctrl_pipe #(
    parameter int ALU_W      = 5,
    parameter int MEM_STAGES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       instr_i,
    input  logic             instr_vld_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             zflag_i,
    input  logic             sflag_i,
    output logic [ALU_W-1:0] ex_alucntrl_o,
    output logic             ex_alusel_o,
    output logic [2:0]       ex_immsel_o,
    output logic             ex_iformat_o,
    output logic [1:0]       ex_linkreg_o,
    output logic             pc_redirect_o,
    output logic             ex_regjmp_o,
    output logic             mem_enable_o,
    output logic             mem_wr_o,
    output logic             wb_regwrite_o,
    output logic             wb_val2reg_o,
    output logic             wb_pc2reg_o,
    output logic             halt_o,
    output logic             exc_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef struct packed {
        logic [ALU_W-1:0] alu;
        logic             alusel;
        logic [2:0]       imm;
        logic             ifmt;
        logic [1:0]       link;
        logic             rjmp;
        logic             jump;
        logic [3:0]       br;   // one-hot {bgez, bltz, bnez, beqz}
        logic             men;
        logic             mwr;
        logic             rw;
        logic             v2r;
        logic             p2r;
        logic             halt;
        logic             siic;
    } ctl_t;

    function automatic logic [ALU_W-1:0] alu_of(input logic [4:0] v);
        logic [31:0] x;
        x = {27'd0, v};
        return x[ALU_W-1:0];
    endfunction

    function automatic ctl_t decode(input logic [4:0] op);
        ctl_t c;
        c     = '0;
        c.alu = alu_of(op);
        casez (op)
            5'b00000: c.halt = 1'b1;
            5'b00010: c.siic = 1'b1;
            5'b010??, 5'b101??: begin
                c.rw = 1'b1; c.v2r = 1'b1; c.alusel = 1'b1; c.ifmt = 1'b1;
                c.imm = op[1] ? 3'b000 : 3'b100;
            end
            5'b10000: begin
                c.men = 1'b1; c.mwr = 1'b1; c.alu = alu_of(5'b01000);
                c.imm = 3'b100; c.alusel = 1'b1;
            end
            5'b10001: begin
                c.men = 1'b1; c.rw = 1'b1; c.imm = 3'b100; c.alusel = 1'b1; c.ifmt = 1'b1;
            end
            5'b10011: begin
                c.men = 1'b1; c.mwr = 1'b1; c.alu = alu_of(5'b01000); c.imm = 3'b100;
                c.alusel = 1'b1; c.rw = 1'b1; c.v2r = 1'b1; c.link = 2'b01;
            end
            5'b11000, 5'b10010: begin
                c.alu = alu_of(5'b11000); c.imm = op[3] ? 3'b101 : 3'b001;
                c.link = 2'b01; c.rw = 1'b1; c.v2r = 1'b1; c.alusel = 1'b1;
            end
            5'b11001, 5'b1101?, 5'b111??: begin
                c.rw = 1'b1; c.v2r = 1'b1;
            end
            5'b011??: begin
                c.imm = 3'b101; c.br = 4'b0001 << op[1:0];
            end
            5'b001??: begin
                c.alu = alu_of(5'b01000); c.link = 2'b10; c.jump = 1'b1;
                c.imm = op[0] ? 3'b101 : 3'b110;
                c.rjmp = op[0]; c.alusel = op[0];
                c.rw = op[1]; c.p2r = op[1]; c.v2r = op[1];
            end
            default: ;
        endcase
        return c;
    endfunction

    ctl_t                  dec;
    ctl_t                  ex_q;
    ctl_t                  mem_q [MEM_STAGES];
    ctl_t                  wb_q;
    logic                  ex_vld_q;
    logic [MEM_STAGES-1:0] mem_vld_q;
    logic                  wb_vld_q;
    logic                  halt_pend_q, halt_pend_d;
    logic                  halt_q, halt_d;
    logic                  exc_q, exc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  redirect;
    logic                  cap_vld;
    ctl_t                  mem_last;
    logic                  mem_last_vld;

    assign mem_last     = mem_q[MEM_STAGES-1];
    assign mem_last_vld = mem_vld_q[MEM_STAGES-1];

    always_comb begin
        dec         = decode(instr_i);
        redirect    = ex_vld_q & (ex_q.jump |
                      (|(ex_q.br & {!sflag_i, sflag_i, !zflag_i, zflag_i})));
        // A taken redirect kills the younger instruction being fetched this cycle.
        cap_vld     = instr_vld_i & !flush_i & !redirect & !halt_pend_q;
        halt_pend_d = halt_pend_q | (cap_vld & (dec.halt | dec.siic));
        halt_d      = halt_q | (wb_vld_q & wb_q.halt);
        exc_d       = exc_q | (wb_vld_q & wb_q.siic);
        cnt_d       = (redirect && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            ex_vld_q    <= 1'b0;
            mem_vld_q   <= '0;
            wb_q        <= '0;
            wb_vld_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            halt_q      <= 1'b0;
            exc_q       <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < MEM_STAGES; i++) mem_q[i] <= '0;
        end else if (!stall_i) begin
            ex_q         <= dec;
            ex_vld_q     <= cap_vld;
            mem_q[0]     <= ex_q;
            mem_vld_q[0] <= ex_vld_q;
            for (int i = 1; i < MEM_STAGES; i++) begin
                mem_q[i]     <= mem_q[i-1];
                mem_vld_q[i] <= mem_vld_q[i-1];
            end
            wb_q        <= mem_last;
            wb_vld_q    <= mem_last_vld;
            halt_pend_q <= halt_pend_d;
            halt_q      <= halt_d;
            exc_q       <= exc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_alucntrl_o = ex_q.alu & {ALU_W{ex_vld_q}};
    assign ex_alusel_o   = ex_q.alusel & ex_vld_q;
    assign ex_immsel_o   = ex_q.imm & {3{ex_vld_q}};
    assign ex_iformat_o  = ex_q.ifmt & ex_vld_q;
    assign ex_linkreg_o  = ex_q.link & {2{ex_vld_q}};
    assign ex_regjmp_o   = ex_q.rjmp & ex_vld_q;
    assign pc_redirect_o = redirect;
    assign mem_enable_o  = mem_last.men & mem_last_vld;
    assign mem_wr_o      = mem_last.mwr & mem_last_vld;
    assign wb_regwrite_o = wb_q.rw & wb_vld_q;
    assign wb_val2reg_o  = wb_q.v2r & wb_vld_q;
    assign wb_pc2reg_o   = wb_q.p2r & wb_vld_q;
    assign halt_o        = halt_q;
    assign exc_o         = exc_q;
    assign taken_cnt_o   = cnt_q;

    logic unused_bits;
    assign unused_bits = ^{ex_q, mem_last, wb_q};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - decode table, directed corner sequences and random model check
module tb_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, vld, stall, flush, zf, sf;
    logic [4:0] instr;

    logic [4:0] a_alu, b_alu;
    logic [2:0] a_imm, b_imm;
    logic [1:0] a_link, b_link;
    logic       a_alusel, a_ifmt, a_redir, a_rjmp, a_men, a_mwr, a_rw, a_v2r, a_p2r, a_halt, a_exc;
    logic       b_alusel, b_ifmt, b_redir, b_rjmp, b_men, b_mwr, b_rw, b_v2r, b_p2r, b_halt, b_exc;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    ctrl_pipe #(.ALU_W(5), .MEM_STAGES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_vld_i(vld), .stall_i(stall),
        .flush_i(flush), .zflag_i(zf), .sflag_i(sf), .ex_alucntrl_o(a_alu),
        .ex_alusel_o(a_alusel), .ex_immsel_o(a_imm), .ex_iformat_o(a_ifmt),
        .ex_linkreg_o(a_link), .pc_redirect_o(a_redir), .ex_regjmp_o(a_rjmp),
        .mem_enable_o(a_men), .mem_wr_o(a_mwr), .wb_regwrite_o(a_rw), .wb_val2reg_o(a_v2r),
        .wb_pc2reg_o(a_p2r), .halt_o(a_halt), .exc_o(a_exc), .taken_cnt_o(a_cnt));

    ctrl_pipe #(.ALU_W(5), .MEM_STAGES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_vld_i(vld), .stall_i(stall),
        .flush_i(flush), .zflag_i(zf), .sflag_i(sf), .ex_alucntrl_o(b_alu),
        .ex_alusel_o(b_alusel), .ex_immsel_o(b_imm), .ex_iformat_o(b_ifmt),
        .ex_linkreg_o(b_link), .pc_redirect_o(b_redir), .ex_regjmp_o(b_rjmp),
        .mem_enable_o(b_men), .mem_wr_o(b_mwr), .wb_regwrite_o(b_rw), .wb_val2reg_o(b_v2r),
        .wb_pc2reg_o(b_p2r), .halt_o(b_halt), .exc_o(b_exc), .taken_cnt_o(b_cnt));

    typedef struct packed {
        logic [4:0] alu; logic alusel; logic [2:0] imm; logic ifmt; logic [1:0] link;
        logic redir; logic rjmp; logic men; logic mwr; logic rw; logic v2r; logic p2r;
        logic halt; logic exc; logic [15:0] cnt;
    } out_t;

    out_t act_a, act_b;
    assign act_a = {a_alu, a_alusel, a_imm, a_ifmt, a_link, a_redir, a_rjmp, a_men, a_mwr,
                    a_rw, a_v2r, a_p2r, a_halt, a_exc, a_cnt};
    assign act_b = {b_alu, b_alusel, b_imm, b_ifmt, b_link, b_redir, b_rjmp, b_men, b_mwr,
                    b_rw, b_v2r, b_p2r, b_halt, b_exc, {14'd0, b_cnt}};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vld = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct packed { logic [4:0] op; logic vld; } ent_t;
    ent_t        hist[$];
    logic        hp_m;
    logic        h_m [2];
    logic        e_m [2];
    logic [15:0] c_m [2];
    int          ms_m [2]   = '{1, 3};
    logic [15:0] cmax_m [2] = '{16'hffff, 16'd3};

    function automatic out_t ref_dec(input logic [4:0] op);
        out_t o;
        bit alui, rtype, br, jmp;
        o     = '0;
        alui  = (op[4:2] == 3'b010) || (op[4:2] == 3'b101);
        rtype = (op == 5'b11001) || (op[4:1] == 4'b1101) || (op[4:2] == 3'b111);
        br    = (op[4:2] == 3'b011);
        jmp   = (op[4:2] == 3'b001);
        o.alu = op;
        if (alui) begin
            o.rw = 1; o.v2r = 1; o.alusel = 1; o.ifmt = 1; o.imm = (op[1] == 1'b1) ? 3'b000 : 3'b100;
        end else if (rtype) begin
            o.rw = 1; o.v2r = 1;
        end else if (br) begin
            o.imm = 3'b101;
        end else if (jmp) begin
            o.alu = 5'b01000; o.link = 2'b10;
            if (op == 5'b00101 || op == 5'b00111) begin o.imm = 3'b101; o.rjmp = 1; o.alusel = 1; end
            else o.imm = 3'b110;
            if (op == 5'b00110 || op == 5'b00111) begin o.rw = 1; o.p2r = 1; o.v2r = 1; end
        end else begin
            case (op)
                5'b10000: begin o.alu = 5'b01000; o.imm = 3'b100; o.alusel = 1; o.men = 1; o.mwr = 1; end
                5'b10001: begin o.imm = 3'b100; o.alusel = 1; o.ifmt = 1; o.men = 1; o.rw = 1; end
                5'b10011: begin o.alu = 5'b01000; o.imm = 3'b100; o.alusel = 1; o.link = 2'b01;
                                o.men = 1; o.mwr = 1; o.rw = 1; o.v2r = 1; end
                5'b11000: begin o.alu = 5'b11000; o.imm = 3'b101; o.link = 2'b01; o.alusel = 1;
                                o.rw = 1; o.v2r = 1; end
                5'b10010: begin o.alu = 5'b11000; o.imm = 3'b001; o.link = 2'b01; o.alusel = 1;
                                o.rw = 1; o.v2r = 1; end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic bit ref_taken(input logic [4:0] op, input logic z, input logic s);
        if (op[4:2] == 3'b001) return 1'b1;
        if (op[4:2] != 3'b011) return 1'b0;
        case (op[1:0])
            2'd0: return z;
            2'd1: return !z;
            2'd2: return s;
            default: return !s;
        endcase
    endfunction

    function automatic ent_t stage_ent(input int depth);
        if (hist.size() > depth) return hist[hist.size() - 1 - depth];
        return '0;
    endfunction

    function automatic out_t model_out(input int d);
        out_t o, ex, mm, wb;
        ent_t e0, e1, e2;
        e0 = stage_ent(0); e1 = stage_ent(ms_m[d]); e2 = stage_ent(ms_m[d] + 1);
        ex = e0.vld ? ref_dec(e0.op) : '0;
        mm = e1.vld ? ref_dec(e1.op) : '0;
        wb = e2.vld ? ref_dec(e2.op) : '0;
        o = '0;
        o.alu = ex.alu; o.alusel = ex.alusel; o.imm = ex.imm; o.ifmt = ex.ifmt; o.link = ex.link;
        o.rjmp = ex.rjmp; o.redir = e0.vld & ref_taken(e0.op, zf, sf);
        o.men = mm.men; o.mwr = mm.mwr;
        o.rw = wb.rw; o.v2r = wb.v2r; o.p2r = wb.p2r;
        o.halt = h_m[d]; o.exc = e_m[d]; o.cnt = c_m[d];
        return o;
    endfunction

    task automatic model_edge();
        ent_t e0, w;
        bit redir, cap;
        if (!rst_n) begin
            hist.delete(); hp_m = 0;
            for (int d = 0; d < 2; d++) begin h_m[d] = 0; e_m[d] = 0; c_m[d] = 0; end
        end else if (!stall) begin
            e0 = stage_ent(0);
            redir = e0.vld & ref_taken(e0.op, zf, sf);
            for (int d = 0; d < 2; d++) begin
                if (redir && c_m[d] != cmax_m[d]) c_m[d] = c_m[d] + 16'd1;
                w = stage_ent(ms_m[d] + 1);
                if (w.vld && w.op == 5'b00000) h_m[d] = 1;
                if (w.vld && w.op == 5'b00010) e_m[d] = 1;
            end
            cap = vld & !flush & !redir & !hp_m;
            if (cap && (instr == 5'b00000 || instr == 5'b00010)) hp_m = 1;
            hist.push_back('{instr, cap});
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [4:0]  op;
        logic [13:0] ex;   // {alu, alusel, imm, ifmt, link, rjmp, redir} with Z=1, S=1
        logic [1:0]  mem;  // {men, mwr}
        logic [2:0]  wb;   // {rw, v2r, p2r}
    } vec_t;
    vec_t tbl [18];

    initial begin
        tbl[0]  = '{5'b00001, {5'b00001, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b000};
        tbl[1]  = '{5'b01000, {5'b01000, 1'b1, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b110};
        tbl[2]  = '{5'b01010, {5'b01010, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b110};
        tbl[3]  = '{5'b10101, {5'b10101, 1'b1, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b110};
        tbl[4]  = '{5'b10000, {5'b01000, 1'b1, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0}, 2'b11, 3'b000};
        tbl[5]  = '{5'b10001, {5'b10001, 1'b1, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0}, 2'b10, 3'b100};
        tbl[6]  = '{5'b10011, {5'b01000, 1'b1, 3'b100, 1'b0, 2'b01, 1'b0, 1'b0}, 2'b11, 3'b110};
        tbl[7]  = '{5'b11000, {5'b11000, 1'b1, 3'b101, 1'b0, 2'b01, 1'b0, 1'b0}, 2'b00, 3'b110};
        tbl[8]  = '{5'b10010, {5'b11000, 1'b1, 3'b001, 1'b0, 2'b01, 1'b0, 1'b0}, 2'b00, 3'b110};
        tbl[9]  = '{5'b11011, {5'b11011, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b110};
        tbl[10] = '{5'b01100, {5'b01100, 1'b0, 3'b101, 1'b0, 2'b00, 1'b0, 1'b1}, 2'b00, 3'b000};
        tbl[11] = '{5'b01101, {5'b01101, 1'b0, 3'b101, 1'b0, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b000};
        tbl[12] = '{5'b01110, {5'b01110, 1'b0, 3'b101, 1'b0, 2'b00, 1'b0, 1'b1}, 2'b00, 3'b000};
        tbl[13] = '{5'b00100, {5'b01000, 1'b0, 3'b110, 1'b0, 2'b10, 1'b0, 1'b1}, 2'b00, 3'b000};
        tbl[14] = '{5'b00110, {5'b01000, 1'b0, 3'b110, 1'b0, 2'b10, 1'b0, 1'b1}, 2'b00, 3'b111};
        tbl[15] = '{5'b00111, {5'b01000, 1'b1, 3'b101, 1'b0, 2'b10, 1'b1, 1'b1}, 2'b00, 3'b111};
        tbl[16] = '{5'b00000, {5'b00000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b000};
        tbl[17] = '{5'b00010, {5'b00010, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0}, 2'b00, 3'b000};

        rst_n = 1'b0; vld = 1'b0; stall = 1'b0; flush = 1'b0; zf = 1'b0; sf = 1'b0; instr = '0;

        // Reset with random inputs: every output zero.
        for (int i = 0; i < 2; i++) begin
            instr = 5'($urandom_range(31)); vld = 1'b1; zf = 1'($urandom_range(1));
            sf = 1'($urandom_range(1));
            tick();
            chk("reset_a", 64'(act_a), 64'd0);
            chk("reset_b", 64'(act_b), 64'd0);
        end
        rst_n = 1'b1; instr = 5'b10001; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        chk("ld_mem_en", 64'(a_men), 64'd1);
        tick();
        chk("ld_wb", 64'({a_rw, a_v2r}), 64'(2'b10));

        foreach (tbl[r]) begin
            do_reset();
            zf = 1'b1; sf = 1'b1; instr = tbl[r].op; vld = 1'b1;
            tick();
            vld = 1'b0;
            chk($sformatf("tbl_ex_%0d", r),
                64'({a_alu, a_alusel, a_imm, a_ifmt, a_link, a_rjmp, a_redir}), 64'(tbl[r].ex));
            tick();
            chk($sformatf("tbl_mem_%0d", r), 64'({a_men, a_mwr}), 64'(tbl[r].mem));
            tick();
            chk($sformatf("tbl_wb_%0d", r), 64'({a_rw, a_v2r, a_p2r}), 64'(tbl[r].wb));
        end

        // Taken BEQZ kills the following ADDI.
        do_reset();
        zf = 1'b1; sf = 1'b0; instr = 5'b01100; vld = 1'b1;
        tick();
        chk("beqz_redir", 64'(a_redir), 64'd1);
        instr = 5'b01000;
        tick();
        vld = 1'b0;
        chk("beqz_redir_once", 64'(a_redir), 64'd0);
        chk("beqz_cnt", 64'(a_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("beqz_addi_killed", 64'(a_rw), 64'd0);
        end

        // Not-taken BEQZ lets ADDI retire.
        do_reset();
        zf = 1'b0; instr = 5'b01100; vld = 1'b1;
        tick();
        chk("beqz_nt_redir", 64'(a_redir), 64'd0);
        instr = 5'b01000;
        tick();
        vld = 1'b0;
        tick();
        tick();
        chk("beqz_nt_addi_wb", 64'({a_rw, a_v2r}), 64'(2'b11));
        chk("beqz_nt_cnt", 64'(a_cnt), 64'd0);

        // JAL held in EX across a 3-cycle stall.
        do_reset();
        instr = 5'b00110; vld = 1'b1;
        tick();
        vld = 1'b0; stall = 1'b1;
        chk("jal_link", 64'(a_link), 64'(2'b10));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_redir_held", 64'(a_redir), 64'd1);
            chk("stall_cnt_hold", 64'(a_cnt), 64'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_cnt", 64'(a_cnt), 64'd1);
        chk("stall_release_redir", 64'(a_redir), 64'd0);
        tick();
        chk("jal_wb", 64'({a_rw, a_p2r}), 64'(2'b11));

        // HALT followed by ADDs.
        do_reset();
        instr = 5'b00000; vld = 1'b1;
        tick();
        instr = 5'b11011;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("halt_ex_bubble", 64'(a_alu), 64'd0);
            chk("halt_no_wb", 64'(a_rw), 64'd0);
            chk($sformatf("halt_flag_e%0d", e), 64'(a_halt), 64'(e >= 3));
        end
        vld = 1'b0;
        do_reset();
        chk("halt_cleared", 64'(a_halt), 64'd0);

        // Saturating counter on the CNT_W=2 instance.
        do_reset();
        instr = 5'b00100; vld = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        tick();
        vld = 1'b0;
        tick();
        chk("sat_cnt_b", 64'(b_cnt), 64'd3);
        chk("nosat_cnt_a", 64'(a_cnt), 64'd6);

        // MEM_STAGES=3 LD latency.
        do_reset();
        instr = 5'b10001; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        tick();
        chk("ms3_mem_early", 64'(b_men), 64'd0);
        tick();
        chk("ms3_mem_en", 64'(b_men), 64'd1);
        tick();
        chk("ms3_wb", 64'({b_rw, b_v2r}), 64'(2'b10));

        // Reset while ST sits in MEM and JALR in EX.
        do_reset();
        instr = 5'b10000; vld = 1'b1;
        tick();
        instr = 5'b00111;
        tick();
        vld = 1'b0;
        chk("mid_pre_mwr", 64'({a_mwr, a_redir}), 64'(2'b11));
        rst_n = 1'b0;
        tick();
        chk("mid_rst_out", 64'(act_a), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_nothing_retires", 64'(act_a), 64'd0);
        end

        // Random stimulus against the reference model on both instances.
        for (int i = 0; i < 3000; i++) begin
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(99) >= 2);
            stall = ($urandom_range(99) < 20);
            flush = ($urandom_range(99) < 8);
            vld   = ($urandom_range(99) < 85);
            zf    = 1'($urandom_range(1));
            sf    = 1'($urandom_range(1));
            instr = 5'($urandom_range(31));
            if ((instr == 5'b00000 || instr == 5'b00010) && $urandom_range(9) != 0) instr = 5'b01001;
            #2;
            chk("rand_a", 64'(act_a), 64'(model_out(0)));
            chk("rand_b", 64'(act_b), 64'(model_out(1)));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
